// File: rtl/evm_pkg.sv
// Shared EVM constants and the tally/report FSM state encoding.
package evm_pkg;
  localparam int PCT_SCALE = 100;
  localparam int PCT_W     = 8;

  typedef enum logic [2:0] {
    VOTING,
    CLOSED,
    REP_SET,
    REP_CAP,
    DONE
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat is high at all-ones.
// Single-cycle update; increments at saturation are ignored.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  assign sat = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/vote_tally.sv
// Per-candidate vote tally; reports floor percentages through an external divider, first strobe 3 cycles after report_req, then every 2.
// vote_ready gates votes outside VOTING; define VOTE_TALLY_WINNER_EN for the winner/winner_valid outputs.
module vote_tally
  import evm_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int DIV_W    = 16,
  parameter int CAND_W   = $clog2(NUM_CAND)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              vote_valid,
  input  logic [CAND_W-1:0] vote_cand,
  output logic              vote_ready,
  input  logic              close,
  input  logic              report_req,
  output logic [DIV_W-1:0]  div_a,
  output logic [DIV_W-1:0]  div_b,
  input  logic [DIV_W-1:0]  div_res,
  output logic              pct_valid,
  output logic [CAND_W-1:0] pct_cand,
  output logic [PCT_W-1:0]  pct_value,
  output logic [DIV_W-1:0]  total,
  output logic              overflow,
  output logic              done
`ifdef VOTE_TALLY_WINNER_EN
  ,
  output logic [CAND_W-1:0] winner,
  output logic              winner_valid
`endif
);
  state_t              state, state_nx;
  logic [CAND_W-1:0]   k;
  logic [CNT_W-1:0]    cnt [NUM_CAND];
  logic [NUM_CAND-1:0] sat;
  logic [NUM_CAND-1:0] inc;
  logic                accept;
  logic                tgt_sat;
  logic [CNT_W-1:0]    cnt_k;
  logic                last;
  logic                unused_div_hi;

  // Quotient never exceeds 100, so only the low byte matters.
  assign unused_div_hi = ^div_res[DIV_W-1:PCT_W];
  assign last = (k == CAND_W'(NUM_CAND - 1));

  always_comb begin
    accept  = vote_valid && vote_ready && (state == VOTING) && !clr
              && (32'(vote_cand) < NUM_CAND);
    tgt_sat = 1'b0;
    cnt_k   = '0;
    inc     = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_cand == CAND_W'(i)) tgt_sat = sat[i];
      if (k == CAND_W'(i)) cnt_k = cnt[i];
      inc[i] = accept && (vote_cand == CAND_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc[g]),
      .cnt   (cnt[g]),
      .sat   (sat[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= VOTING;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = VOTING;
    end else begin
      case (state)
        VOTING:  if (close) state_nx = CLOSED;
        CLOSED:  if (report_req) state_nx = REP_SET;
        REP_SET: state_nx = REP_CAP;
        REP_CAP: state_nx = last ? DONE : REP_SET;
        DONE:    state_nx = DONE;
        default: state_nx = VOTING;
      endcase
    end
  end

`ifdef VOTE_TALLY_WINNER_EN
  logic [CNT_W-1:0] best_cnt;

  // Strict '>' keeps the lowest index on ties; an empty poll leaves winner at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_cnt     <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
    end else if (clr) begin
      best_cnt     <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
    end else if (state == REP_CAP) begin
      if (k == '0 || cnt_k > best_cnt) begin
        best_cnt <= cnt_k;
        winner   <= k;
      end
      if (last) winner_valid <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_ready <= 1'b0;
      k          <= '0;
      total      <= '0;
      div_a      <= '0;
      div_b      <= '0;
      pct_valid  <= 1'b0;
      pct_cand   <= '0;
      pct_value  <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      pct_valid  <= 1'b0;
      vote_ready <= (state_nx == VOTING);
      if (clr) begin
        k         <= '0;
        total     <= '0;
        div_a     <= '0;
        div_b     <= '0;
        pct_cand  <= '0;
        pct_value <= '0;
        overflow  <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          VOTING: begin
            if (accept) begin
              if (tgt_sat) overflow <= 1'b1;
              else         total    <= total + 1'b1;
            end
          end
          CLOSED: begin
            if (report_req) k <= '0;
          end
          REP_SET: begin
            div_a <= DIV_W'(cnt_k) * DIV_W'(PCT_SCALE);
            div_b <= (total == '0) ? DIV_W'(1) : total;
          end
          REP_CAP: begin
            pct_value <= (total == '0) ? '0 : div_res[PCT_W-1:0];
            pct_cand  <= k;
            pct_valid <= 1'b1;
            if (last) done <= 1'b1;
            else      k    <= k + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: table of poll scenarios plus hand sequences for saturation, reset and clear.
module tb_vote_tally;
  localparam int NC = 4;
  localparam int CW = 8;
  localparam int DW = 16;
  localparam int KW = 3;   // one spare bit so out-of-range candidate indices are expressible

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          vote_valid = 1'b0;
  logic [KW-1:0] vote_cand = '0;
  logic          close = 1'b0;
  logic          report_req = 1'b0;
  logic          vote_ready;
  logic [DW-1:0] div_a, div_b, div_res, total;
  logic          pct_valid, overflow, done;
  logic [KW-1:0] pct_cand;
  logic [7:0]    pct_value;
`ifdef VOTE_TALLY_WINNER_EN
  logic [KW-1:0] winner;
  logic          winner_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external division block.
  assign div_res = (div_b != '0) ? div_a / div_b : '0;

  vote_tally #(.NUM_CAND(NC), .CNT_W(CW), .DIV_W(DW), .CAND_W(KW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .vote_valid (vote_valid),
    .vote_cand  (vote_cand),
    .vote_ready (vote_ready),
    .close      (close),
    .report_req (report_req),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_res    (div_res),
    .pct_valid  (pct_valid),
    .pct_cand   (pct_cand),
    .pct_value  (pct_value),
    .total      (total),
    .overflow   (overflow),
    .done       (done)
`ifdef VOTE_TALLY_WINNER_EN
    ,
    .winner       (winner),
    .winner_valid (winner_valid)
`endif
  );

  typedef struct packed {
    logic [3:0][8:0] votes;  // indexed by candidate; literals list cand3..cand0
    logic [3:0][7:0] pct;
    logic [15:0]     tot;
    logic [2:0]      win;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cast_votes(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vote_valid = 1'b1;
      vote_cand  = KW'(c);
    end
    @(negedge clk);
    vote_valid = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic do_close;
    @(negedge clk); close = 1'b1;
    @(negedge clk); close = 1'b0;
    check("ready_after_close", 32'(vote_ready), 32'd0);
  endtask

  task automatic run_report(input logic [3:0][7:0] pct, input int exp_divb, input int exp_win);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 1;
    @(negedge clk); report_req = 1'b1;
    @(negedge clk); report_req = 1'b0;
    while (seen < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      check("no_x", 32'($isunknown({vote_ready, div_a, div_b, pct_valid, pct_cand,
                                     pct_value, total, overflow, done})), 32'd0);
      if (pct_valid) begin
        check("strobe_cycle", 32'(cyc), 32'(3 + 2 * seen));
        check("pct_cand", 32'(pct_cand), 32'(seen));
        check("pct_value", 32'(pct_value), 32'(pct[seen]));
        check("div_b", 32'(div_b), 32'(exp_divb));
        check("done_with_strobe", 32'(done), 32'(seen == 3));
`ifdef VOTE_TALLY_WINNER_EN
        check("winner_valid", 32'(winner_valid), 32'(seen == 3));
        if (seen == 3) check("winner", 32'(winner), 32'(exp_win));
`endif
        seen++;
      end else begin
        check("done_early", 32'(done), 32'd0);
      end
    end
    check("strobe_count", 32'(seen), 32'd4);
    @(negedge clk);
    check("done_hold", 32'(done), 32'd1);
    check("strobe_single", 32'(pct_valid), 32'd0);
    if (exp_win < 0) $display("unexpected winner argument");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int guard;

    tbl[0] = '{votes: {9'd0, 9'd0, 9'd1, 9'd3}, pct: {8'd0, 8'd0, 8'd25, 8'd75}, tot: 16'd4, win: 3'd0};
    tbl[1] = '{votes: {9'd0, 9'd1, 9'd1, 9'd1}, pct: {8'd0, 8'd33, 8'd33, 8'd33}, tot: 16'd3, win: 3'd0};
    tbl[2] = '{votes: {9'd0, 9'd0, 9'd0, 9'd0}, pct: {8'd0, 8'd0, 8'd0, 8'd0}, tot: 16'd0, win: 3'd0};
    tbl[3] = '{votes: {9'd0, 9'd1, 9'd2, 9'd2}, pct: {8'd0, 8'd20, 8'd40, 8'd40}, tot: 16'd5, win: 3'd0};
    tbl[4] = '{votes: {9'd1, 9'd5, 9'd3, 9'd0}, pct: {8'd11, 8'd55, 8'd33, 8'd0}, tot: 16'd9, win: 3'd2};

    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(vote_ready), 32'd0);
    check("rst_total", 32'(total), 32'd0);
    check("rst_div_a", 32'(div_a), 32'd0);
    check("rst_div_b", 32'(div_b), 32'd0);
    check("rst_pct", 32'({pct_valid, pct_cand, pct_value}), 32'd0);
    check("rst_flags", 32'({overflow, done}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(vote_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      pulse_clr();
      check("tbl_ready", 32'(vote_ready), 32'd1);
      check("tbl_total0", 32'(total), 32'd0);
      for (int c = 0; c < NC; c++) cast_votes(c, int'(tbl[i].votes[c]));
      check("tbl_total", 32'(total), 32'(tbl[i].tot));
      do_close();
      run_report(tbl[i].pct, (tbl[i].tot == 16'd0) ? 1 : int'(tbl[i].tot), int'(tbl[i].win));
    end

    // Saturation, out-of-range candidate, vote coincident with close
    pulse_clr();
    cast_votes(2, 255);
    check("sat_total", 32'(total), 32'd255);
    check("sat_ovf_pre", 32'(overflow), 32'd0);
    @(negedge clk); report_req = 1'b1;
    @(negedge clk); report_req = 1'b0;
    repeat (3) @(negedge clk);
    check("req_ignored_ready", 32'(vote_ready), 32'd1);
    check("req_ignored_strobe", 32'(pct_valid), 32'd0);
    cast_votes(2, 1);
    check("sat_ovf", 32'(overflow), 32'd1);
    check("sat_total_hold", 32'(total), 32'd255);
    cast_votes(5, 1);
    check("bad_cand_total", 32'(total), 32'd255);
    @(negedge clk); vote_valid = 1'b1; vote_cand = 3'd0; close = 1'b1;
    @(negedge clk); vote_valid = 1'b0; close = 1'b0;
    check("close_vote_counted", 32'(total), 32'd256);
    check("close_ready", 32'(vote_ready), 32'd0);
    cast_votes(1, 2);
    check("closed_vote_ignored", 32'(total), 32'd256);
    run_report({8'd0, 8'd99, 8'd0, 8'd0}, 256, 2);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset in the middle of a report
    pulse_clr();
    cast_votes(0, 3);
    cast_votes(1, 1);
    do_close();
    @(negedge clk); report_req = 1'b1;
    @(negedge clk); report_req = 1'b0;
    seen  = 0;
    guard = 0;
    while (seen < 2 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (pct_valid) seen++;
    end
    check("mid_strobes", 32'(seen), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(vote_ready), 32'd0);
    check("mid_rst_total", 32'(total), 32'd0);
    check("mid_rst_div", 32'({div_a, div_b}), 32'd0);
    check("mid_rst_pct", 32'({pct_valid, pct_cand, pct_value}), 32'd0);
    check("mid_rst_flags", 32'({overflow, done}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_strobe", 32'(pct_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_back", 32'(vote_ready), 32'd1);

    // Clear out of DONE
    cast_votes(1, 2);
    do_close();
    run_report({8'd0, 8'd0, 8'd100, 8'd0}, 2, 1);
    pulse_clr();
    check("clr_ready", 32'(vote_ready), 32'd1);
    check("clr_done", 32'(done), 32'd0);
    check("clr_total", 32'(total), 32'd0);
    check("clr_div", 32'({div_a, div_b}), 32'd0);
    check("clr_pct", 32'({pct_cand, pct_value}), 32'd0);
    do_close();
    run_report({8'd0, 8'd0, 8'd0, 8'd0}, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Per-candidate vote counter for the EVM datapath, directly upstream of the combinational `division` block.
- Accepts votes while polling is open, then runs a report sequence when asked.
- For each candidate, the report drives the external divider with dividend = votes×100 and divisor = total, then captures the integer percentage.
- `division` is instantiated outside this block with `WIDTH = DIV_W`.

Parameters:
- NUM_CAND, 4: number of candidates, 2..16.
- CNT_W, 8: per-candidate counter width; counters saturate at 2^CNT_W−1.
- DIV_W, 16: divider operand width; must hold (2^CNT_W−1)×100 and NUM_CAND×(2^CNT_W−1).
- CAND_W, $clog2(NUM_CAND): candidate index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset.
- clr  in  1  synchronous clear: zero all counters and flags, return to VOTING.
- vote_valid  in  1  vote presented.
- vote_cand  in  CAND_W  candidate index of the vote.
- vote_ready  out  1  votes are accepted this cycle.
- close  in  1  pulse: end polling.
- report_req  in  1  pulse: start the percentage report.
- div_a  out  DIV_W  dividend to `division`.
- div_b  out  DIV_W  divisor to `division`.
- div_res  in  DIV_W  quotient from `division`.
- pct_valid  out  1  one-cycle strobe: pct_cand/pct_value are valid.
- pct_cand  out  CAND_W  candidate being reported.
- pct_value  out  8  floor percentage, 0..100.
- total  out  DIV_W  sum of all accepted votes.
- overflow  out  1  sticky: a vote was dropped due to counter saturation.
- done  out  1  report finished; held high.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all counters, total, div_a, div_b, pct_*, overflow and done are 0; state = VOTING; vote_ready = 0.
- vote_ready is a registered flag; it rises on the first clk edge after reset release while in VOTING.
- States: VOTING → CLOSED → REP_SET ⇄ REP_CAP → DONE.
- VOTING:
  - A vote is accepted when vote_valid && vote_ready.
  - If vote_cand ≥ NUM_CAND, the vote is silently ignored.
  - If the target counter is saturated, the vote is dropped and overflow is set; total is not incremented.
  - Otherwise the counter and total increment on the same edge.
  - close moves the FSM to CLOSED. A vote accepted in the same cycle as close is counted.
  - vote_ready drops on the edge that leaves VOTING.
- CLOSED: report_req moves to REP_SET with k = 0. report_req in any other state is ignored.
- REP_SET (one cycle):
  - Register div_a = cnt[k]×100, zero-extended.
  - Register div_b = total, or 1 if total == 0 (never divide by zero).
  - Go to REP_CAP.
- REP_CAP (one cycle):
  - Register pct_value = div_res[7:0], or 0 if total == 0.
  - Register pct_cand = k and pulse pct_valid on the next cycle.
  - If k == NUM_CAND−1, go to DONE; otherwise increment k and go to REP_SET.
- Latency: first pct_valid 3 cycles after report_req. Successive strobes are 2 cycles apart. done rises in the same cycle as the last pct_valid.
- DONE: all outputs hold. Only clr or reset leave this state.
- clr: takes priority over every other input in every state, including mid-report. It zeroes everything, returns to VOTING and sets vote_ready = 1 on the next edge.
- Reset mid-report: async clear to reset values; no partial pct_valid is emitted.
- Arithmetic: ×100 is a constant multiply in DIV_W bits. Results are floor division, so per-candidate sums may total < 100.

Optional Feature:
- Macro: VOTE_TALLY_WINNER_EN.
- When defined:
  - Adds outputs winner (CAND_W) and winner_valid (1).
  - The block tracks the maximum count during REP_CAP; ties go to the lowest index.
  - winner_valid asserts with done.
  - If total == 0, winner = 0 and winner_valid = 1.
- When undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package `evm_pkg` holds:
  - localparams PCT_SCALE = 100 and PCT_W = 8.
  - The FSM state enum {VOTING, CLOSED, REP_SET, REP_CAP, DONE}.
- Natural sub-module: `sat_counter`, a CNT_W-bit counter with inc, clr and a sat flag. It is instantiated NUM_CAND times.

Test Plan:
- Votes: cand0 ×3, cand1 ×1; close; report_req → pct sequence (0,75), (1,25), (2,0), (3,0); total = 4; done high with the 4th strobe; div_b = 4 throughout.
- One vote each to cand0..2; report → 33, 33, 33, 0 (floor).
- No votes; close; report → four strobes, all pct_value = 0; div_b = 1; no X on any output.
- 256 votes to cand2 → cnt2 = 255, total = 255, overflow = 1. Vote with vote_cand = 5 (NUM_CAND = 4) → no change. Vote in the same cycle as close → counted.
- rst_n low in REP_CAP after 2 strobes → all outputs 0 immediately. clr while in DONE → VOTING, counters 0, vote_ready = 1 the next cycle.
- With VOTE_TALLY_WINNER_EN: votes 2, 2, 1, 0 → winner = 0, winner_valid with done. With no votes → winner = 0.
